draw_scheduler: RTL

DRAW_SCHEDULER -- requirements
Module: draw_scheduler

---
 rtl/vga_pkg.sv | 33 +++
 rtl/draw_watchdog.sv | 41 ++++
 rtl/draw_scheduler.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared codes for the draw scheduler: scene, dog action and dreidel state
// encodings plus the scheduler FSM state type.
package vga_pkg;

    localparam logic [3:0] LOC_ROOT   = 4'h0;
    localparam logic [3:0] LOC_HOME   = 4'h1;
    localparam logic [3:0] LOC_ARCADE = 4'h2;
    localparam logic [3:0] LOC_GAME   = 4'h3;
    localparam logic [3:0] LOC_END    = 4'hF;

    localparam logic [3:0] ACT_STAY   = 4'h0;
    localparam logic [3:0] ACT_EAT    = 4'h1;
    localparam logic [3:0] ACT_SLEEP  = 4'h2;
    localparam logic [3:0] ACT_GAME   = 4'h3;

    localparam logic [3:0] GS_SPIN    = 4'h1;
    localparam logic [3:0] GS_NUN     = 4'h2;
    localparam logic [3:0] GS_GIMEL   = 4'h3;
    localparam logic [3:0] GS_HAY     = 4'h4;
    localparam logic [3:0] GS_SHIN    = 4'h5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RELEASE = 2'd2
    } sched_state_t;

    // Animation ticks only matter while the spinning dreidel is on screen.
    function automatic logic anim_qualifies(input logic [3:0] loc, input logic [3:0] gs);
        return (loc == LOC_GAME) && (gs == GS_SPIN);
    endfunction

endpackage

// File: rtl/draw_watchdog.sv
// Timeout counter for one renderer draw.
// Ports:
//   clk, reset : clock, async active-high reset
//   clear      : force the count back to zero
//   enable     : count one cycle
//   expired    : count has reached TIMEOUT_CYCLES-1
module draw_watchdog #(
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int CNT_W          = 17
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q, count_d;

    assign expired = (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !expired) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/draw_scheduler.sv
// Decides when the renderer must redraw and holds a stable snapshot of the
// scene while it does.
// Ports:
//   clk, reset                        : clock, async active-high reset
//   location, action, gameState       : requested scene
//   forceRedraw, animTick             : redraw request pulses
//   drawDone                          : renderer done level
//   drawStart                         : renderer start level
//   locationOut/actionOut/gameStateOut: snapshot given to the renderer
//   busy, timeoutErr, redrawCount     : status
//
// state   | meaning
// IDLE    | no draw in progress, watching for a request
// WAIT    | drawStart high, waiting for drawDone or the watchdog
// RELEASE | draw finished or aborted, waiting for drawDone to drop
module draw_scheduler
    import vga_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int CNT_W          = 17
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] location,
    input  logic [3:0] action,
    input  logic [3:0] gameState,
    input  logic       forceRedraw,
    input  logic       animTick,
    input  logic       drawDone,
    output logic       drawStart,
    output logic [3:0] locationOut,
    output logic [3:0] actionOut,
    output logic [3:0] gameStateOut,
    output logic       busy,
    output logic       timeoutErr,
    output logic [7:0] redrawCount
);

    sched_state_t state_q, state_d;
    logic [3:0]   loc_q, loc_d, act_q, act_d, gs_q, gs_d;
    logic         pending_q, pending_d;
    logic         timeout_err_q, timeout_err_d;
    logic [7:0]   redraw_cnt_q, redraw_cnt_d;
    logic         draw_start_q, draw_start_d;
    logic         busy_q, busy_d;

    logic wd_clear, wd_enable, wd_expired;
    logic redraw_event, inputs_changed, req;

    draw_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expired(wd_expired)
    );

    // Held at zero outside WAIT so every draw starts a fresh timeout.
    assign wd_clear  = (state_q != ST_WAIT);
    assign wd_enable = (state_q == ST_WAIT) && !drawDone;

    // Animation qualification looks at the snapshot, i.e. what is on screen.
    assign redraw_event   = forceRedraw || (animTick && anim_qualifies(loc_q, gs_q));
    assign inputs_changed = ({location, action, gameState} != {loc_q, act_q, gs_q});
    assign req            = inputs_changed || pending_q || redraw_event;

    always_comb begin
        state_d       = state_q;
        loc_d         = loc_q;
        act_d         = act_q;
        gs_d          = gs_q;
        pending_d     = pending_q;
        timeout_err_d = timeout_err_q;
        redraw_cnt_d  = redraw_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    loc_d     = location;
                    act_d     = action;
                    gs_d      = gameState;
                    pending_d = 1'b0;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redraw_event) pending_d = 1'b1;
                // A done on the expiry cycle counts as a normal completion.
                if (drawDone) begin
                    redraw_cnt_d = redraw_cnt_q + 8'd1;
                    state_d      = ST_RELEASE;
                end else if (wd_expired) begin
                    timeout_err_d = 1'b1;
                    pending_d     = 1'b1;
                    state_d       = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (redraw_event) pending_d = 1'b1;
                if (!drawDone) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        draw_start_d = (state_d == ST_WAIT);
        busy_d       = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            loc_q         <= '0;
            act_q         <= '0;
            gs_q          <= '0;
            pending_q     <= 1'b1;
            timeout_err_q <= 1'b0;
            redraw_cnt_q  <= '0;
            draw_start_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            loc_q         <= loc_d;
            act_q         <= act_d;
            gs_q          <= gs_d;
            pending_q     <= pending_d;
            timeout_err_q <= timeout_err_d;
            redraw_cnt_q  <= redraw_cnt_d;
            draw_start_q  <= draw_start_d;
            busy_q        <= busy_d;
        end
    end

    assign drawStart    = draw_start_q;
    assign busy         = busy_q;
    assign timeoutErr   = timeout_err_q;
    assign redrawCount  = redraw_cnt_q;
    assign locationOut  = loc_q;
    assign actionOut    = act_q;
    assign gameStateOut = gs_q;

endmodule
